// File: rtl/ic74xx_pkg.sv
// Shared types for the 74xx board model: 259 operating modes, frame FSM states
// and the {MR, EN} pin decode.
package ic74xx_pkg;

  typedef enum logic [1:0] {
    LATCH,
    MEMORY,
    DEMUX,
    CLEAR
  } ic259_mode_t;

  typedef enum logic {
    IDLE,
    FILL
  } ic259_frame_st_t;

  // Both pins are active low: MR low selects the clearing modes, EN low enables a write.
  function automatic ic259_mode_t decode_mode(input logic mr_n, input logic en_n);
    ic259_mode_t mode;
    case ({mr_n, en_n})
      2'b10:   mode = LATCH;
      2'b11:   mode = MEMORY;
      2'b00:   mode = DEMUX;
      default: mode = CLEAR;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ic74hc259_frame.sv
// Frame tracker for the 74HC259 model: written-bit mask, IDLE/FILL FSM, snapshot of the
// completed word and a wrapping completed-frame counter.
module ic74hc259_frame
  import ic74xx_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  ic259_mode_t      mode_i,
  input  logic [Width-1:0] sel_onehot_i,
  input  logic [Width-1:0] q_next_i,
  output logic             frame_done_o,
  output logic [Width-1:0] q_frame_o,
  output logic [7:0]       frame_count_o
);

  ic259_frame_st_t state_q, state_d;
  logic [Width-1:0] mask_q, mask_d;
  logic [Width-1:0] mask_set;
  logic             done_q, done_d;
  logic [Width-1:0] q_frame_q, q_frame_d;
  logic [7:0]       count_q, count_d;

  assign mask_set = mask_q | sel_onehot_i;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    q_frame_d = q_frame_q;
    count_d   = count_q;
    unique case (mode_i)
      LATCH: begin
        if (&mask_set) begin
          done_d    = 1'b1;
          q_frame_d = q_next_i;
          count_d   = count_q + 8'd1;
          mask_d    = '0;
          state_d   = IDLE;
        end else begin
          mask_d  = mask_set;
          state_d = FILL;
        end
      end
      MEMORY: ;
      // Any clearing mode destroys the partially built word, so the frame restarts.
      DEMUX, CLEAR: begin
        mask_d  = '0;
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      done_q    <= 1'b0;
      q_frame_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      q_frame_q <= q_frame_d;
      count_q   <= count_d;
    end
  end

  assign frame_done_o  = done_q;
  assign q_frame_o     = q_frame_q;
  assign frame_count_o = count_q;

endmodule

// File: rtl/ic74hc259.sv
// 74HC259 8-bit addressable latch, clocked model. Define IC74HC259_FRAME_EN to build in the
// frame tracker; otherwise Frame_Done, Q_Frame and Frame_Count are tied to 0.
module ic74hc259
  import ic74xx_pkg::*;
#(
  parameter int unsigned DATA_SelectPart  = 3,
  parameter int unsigned DATA_Single_Part = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        EN_Part,
  input  logic                        MR_Part,
  input  logic [DATA_SelectPart-1:0]  SelectPart,
  input  logic                        D,
  output logic [DATA_Single_Part-1:0] Q,
  output logic                        Frame_Done,
  output logic [DATA_Single_Part-1:0] Q_Frame,
  output logic [7:0]                  Frame_Count
);

  if (DATA_Single_Part != (1 << DATA_SelectPart)) begin : g_bad_width
    $error("ic74hc259: DATA_Single_Part must equal 2**DATA_SelectPart");
  end

  ic259_mode_t                 mode;
  logic [DATA_Single_Part-1:0] sel_onehot;
  logic [DATA_Single_Part-1:0] q_q, q_d;

  assign mode = decode_mode(MR_Part, EN_Part);

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < DATA_Single_Part; i++) begin
      sel_onehot[i] = (SelectPart == DATA_SelectPart'(i));
    end
  end

  always_comb begin
    q_d = q_q;
    unique case (mode)
      LATCH:   q_d = (q_q & ~sel_onehot) | (sel_onehot & {DATA_Single_Part{D}});
      MEMORY:  q_d = q_q;
      DEMUX:   q_d = sel_onehot & {DATA_Single_Part{D}};
      CLEAR:   q_d = '0;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifdef IC74HC259_FRAME_EN
  ic74hc259_frame #(
    .Width(DATA_Single_Part)
  ) u_frame (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_i       (mode),
    .sel_onehot_i (sel_onehot),
    .q_next_i     (q_d),
    .frame_done_o (Frame_Done),
    .q_frame_o    (Q_Frame),
    .frame_count_o(Frame_Count)
  );
`else
  assign Frame_Done  = 1'b0;
  assign Q_Frame     = '0;
  assign Frame_Count = '0;
`endif

endmodule

// File: tb/tb_ic74hc259.sv
// Directed, table-driven bench for ic74hc259; frame expectations collapse to 0 when
// IC74HC259_FRAME_EN is not defined.
module tb_ic74hc259;

`ifdef IC74HC259_FRAME_EN
  localparam bit FrameEn = 1'b1;
`else
  localparam bit FrameEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en_n, mr_n, d;
  logic [2:0] sel;
  logic [7:0] q, q_frame, frame_count;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ic74hc259 dut (
    .clk        (clk),
    .rst        (rst),
    .EN_Part    (en_n),
    .MR_Part    (mr_n),
    .SelectPart (sel),
    .D          (d),
    .Q          (q),
    .Frame_Done (frame_done),
    .Q_Frame    (q_frame),
    .Frame_Count(frame_count)
  );

  typedef struct {
    logic       rst;
    logic       mr;
    logic       en;
    logic [2:0] sel;
    logic       d;
    logic [7:0] q;
    logic       done;
    logic [7:0] qf;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive away from the edge, clock once, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic m, input logic e, input logic [2:0] s,
                       input logic dd);
    @(negedge clk);
    rst  = r;
    mr_n = m;
    en_n = e;
    sel  = s;
    d    = dd;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic m, input logic e, input logic [2:0] s,
                              input logic dd, input logic [7:0] eq, input logic edone,
                              input logic [7:0] eqf, input logic [7:0] ecnt);
    vec_t v;
    v.rst = r; v.mr = m; v.en = e; v.sel = s; v.d = dd;
    v.q = eq; v.done = edone; v.qf = eqf; v.cnt = ecnt;
    vecs.push_back(v);
  endfunction

  initial begin
    int pulses;
    logic prev_done;
    logic double_pulse;

    rst = 1'b1; mr_n = 1'b1; en_n = 1'b1; sel = '0; d = 1'b0;

    // rst, mr, en, sel, d  ->  Q, done, Q_Frame, count   (LATCH=10 MEMORY=11 DEMUX=00 CLEAR=01)
    add(1, 0, 0, 3'd7, 1, 8'h00, 0, 8'h00, 8'd0);  // reset with inputs toggling
    add(1, 1, 0, 3'd3, 1, 8'h00, 0, 8'h00, 8'd0);  // reset beats LATCH
    add(0, 1, 0, 3'd5, 1, 8'h20, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd2, 0, 8'h20, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd7, 1, 8'hA0, 0, 8'h00, 8'd0);
    add(0, 1, 1, 3'd0, 1, 8'hA0, 0, 8'h00, 8'd0);  // MEMORY x4
    add(0, 1, 1, 3'd1, 0, 8'hA0, 0, 8'h00, 8'd0);
    add(0, 1, 1, 3'd4, 1, 8'hA0, 0, 8'h00, 8'd0);
    add(0, 1, 1, 3'd6, 1, 8'hA0, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd0, 1, 8'hA1, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd1, 1, 8'hA3, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd3, 1, 8'hAB, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd4, 1, 8'hBB, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd6, 1, 8'hFB, 1, 8'hFB, 8'd1);  // all 8 bits written since reset
    add(0, 1, 0, 3'd2, 1, 8'hFF, 0, 8'hFB, 8'd1);
    add(0, 0, 0, 3'd3, 1, 8'h08, 0, 8'hFB, 8'd1);  // DEMUX from FF
    add(0, 0, 1, 3'd5, 1, 8'h00, 0, 8'hFB, 8'd1);  // CLEAR
    add(1, 1, 0, 3'd0, 1, 8'h00, 0, 8'h00, 8'd0);  // reset before frame fill
    add(0, 1, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd1, 1, 8'h02, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd2, 0, 8'h02, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd3, 1, 8'h0A, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd4, 0, 8'h0A, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd4, 0, 8'h0A, 0, 8'h00, 8'd0);  // repeat leaves the mask unchanged
    add(0, 1, 0, 3'd5, 1, 8'h2A, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd6, 0, 8'h2A, 0, 8'h00, 8'd0);
    add(0, 1, 0, 3'd7, 1, 8'hAA, 1, 8'hAA, 8'd1);
    add(0, 1, 1, 3'd0, 0, 8'hAA, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd0, 1, 8'hAB, 0, 8'hAA, 8'd1);  // six distinct writes, then abort
    add(0, 1, 0, 3'd1, 1, 8'hAB, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd2, 1, 8'hAF, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd3, 1, 8'hAF, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd4, 1, 8'hBF, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd5, 1, 8'hBF, 0, 8'hAA, 8'd1);
    add(0, 0, 1, 3'd0, 0, 8'h00, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd6, 1, 8'h40, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd7, 1, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd0, 0, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd1, 0, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd2, 0, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd3, 0, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd4, 0, 8'hC0, 0, 8'hAA, 8'd1);
    add(0, 1, 0, 3'd5, 0, 8'hC0, 1, 8'hC0, 8'd2);  // refill after the abort completes
    add(0, 1, 1, 3'd5, 0, 8'hC0, 0, 8'hC0, 8'd2);
    add(0, 0, 0, 3'd1, 0, 8'h00, 0, 8'hC0, 8'd2);  // DEMUX writing 0 clears everything

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].mr, vecs[i].en, vecs[i].sel, vecs[i].d);
      check($sformatf("v%0d Q", i), q, vecs[i].q);
      check($sformatf("v%0d Frame_Done", i), frame_done, FrameEn ? vecs[i].done : 1'b0);
      check($sformatf("v%0d Q_Frame", i), q_frame, FrameEn ? vecs[i].qf : 8'h00);
      check($sformatf("v%0d Frame_Count", i), frame_count, FrameEn ? vecs[i].cnt : 8'd0);
    end

    // 256 complete frames: counter reaches 255, then wraps to 0.
    cycle(1, 1, 1, 3'd0, 0);
    pulses = 0;
    prev_done = 1'b0;
    double_pulse = 1'b0;
    for (int f = 0; f < 256; f++) begin
      for (int a = 0; a < 8; a++) begin
        cycle(0, 1, 0, 3'(a), f[0]);
        if (frame_done) pulses++;
        if (frame_done && prev_done) double_pulse = 1'b1;
        prev_done = frame_done;
      end
      if (f == 254) check("count at 255", frame_count, FrameEn ? 8'd255 : 8'd0);
    end
    check("count wrapped", frame_count, 8'd0);
    check("pulse total", pulses, FrameEn ? 256 : 0);
    check("no back-to-back pulse", double_pulse, 1'b0);
    check("last snapshot", q_frame, FrameEn ? 8'hFF : 8'h00);
    check("Q after wrap", q, 8'hFF);

    // Reset mid-frame discards the partial frame; a full refill is needed afterwards.
    cycle(0, 1, 0, 3'd0, 1);
    cycle(0, 1, 0, 3'd1, 1);
    cycle(1, 1, 0, 3'd2, 1);
    check("mid-frame reset Q", q, 8'h00);
    for (int a = 2; a < 8; a++) cycle(0, 1, 0, 3'(a), 1);
    check("no pulse after reset", frame_done, 1'b0);
    cycle(0, 1, 0, 3'd0, 1);
    check("still filling", frame_done, 1'b0);
    cycle(0, 1, 0, 3'd1, 1);
    check("refill pulse", frame_done, FrameEn);
    check("refill count", frame_count, FrameEn ? 8'd1 : 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
